hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: load-use bubbles, branch flushes and a pipeline-wide
// freeze while a data-memory access is outstanding. Also keeps saturating event counters.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RTaddr_i,
    input  logic [4:0]       IFID_RSaddr_i,
    input  logic [4:0]       IFID_RTaddr_i,
    input  logic             IFID_UsesRT_i,
    input  logic             Branch_i,
    input  logic             Dmem_req_i,
    input  logic             Dmem_ack_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             IDEXBubble_o,
    output logic             PipeEn_o,
    output logic             Timeout_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    localparam int WCNT_BITS = $clog2(TIMEOUT + 1);
    localparam int WCNT_W    = (WCNT_BITS > 8) ? WCNT_BITS : 8;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

    typedef enum logic {
        RUN,
        MEMWAIT
    } state_t;

    state_t            state_reg;
    logic [WCNT_W-1:0] wcnt_reg;
    logic              timeout_reg;

    logic in_run;
    logic in_wait;
    logic freeze;
    logic lu;
    logic stall_evt;
    logic flush_evt;

    // Reset forces the RUN view so a mid-wait reset releases the freeze at once.
    assign in_run  = rst_i || (state_reg == RUN);
    assign in_wait = !in_run;

    assign freeze = (in_wait && !Dmem_ack_i) || (in_run && Dmem_req_i && !Dmem_ack_i);

    assign lu = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
                ((IDEX_RTaddr_i == IFID_RSaddr_i) ||
                 (IFID_UsesRT_i && (IDEX_RTaddr_i == IFID_RTaddr_i)));

    assign stall_evt = !freeze && lu;
    assign flush_evt = !freeze && !lu && Branch_i;

    always_comb begin
        PipeEn_o     = 1'b1;
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        IFIDFlush_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        if (freeze) begin
            PipeEn_o    = 1'b0;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
        end else if (lu) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
        end else if (Branch_i) begin
            IFIDFlush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= RUN;
            wcnt_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (Dmem_req_i && !Dmem_ack_i) begin
                        state_reg <= MEMWAIT;
                        wcnt_reg  <= WCNT_W'(1);
                    end
                end
                MEMWAIT: begin
                    if (Dmem_ack_i) begin
                        state_reg <= RUN;
                        wcnt_reg  <= '0;
                    end else if (wcnt_reg == WCNT_MAX) begin
                        state_reg   <= RUN;
                        wcnt_reg    <= '0;
                        timeout_reg <= 1'b1;
                    end else begin
                        wcnt_reg <= wcnt_reg + WCNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= RUN;
                    wcnt_reg  <= '0;
                end
            endcase
        end
    end

    assign Timeout_o = timeout_reg;

    // Index 0 counts load-use bubbles, index 1 counts branch flushes.
    logic [1:0]       cnt_evt;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_evt = {flush_evt, stall_evt};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_evt[gi] && !(&cnt_reg[gi])) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign StallCnt_o = cnt_reg[0];
    assign FlushCnt_o = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters and a short memory timeout.
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RTaddr_i;
    logic [4:0]       IFID_RSaddr_i;
    logic [4:0]       IFID_RTaddr_i;
    logic             IFID_UsesRT_i;
    logic             Branch_i;
    logic             Dmem_req_i;
    logic             Dmem_ack_i;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             IFIDFlush_o;
    logic             IDEXBubble_o;
    logic             PipeEn_o;
    logic             Timeout_o;
    logic [CNT_W-1:0] StallCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_RTaddr_i  (IDEX_RTaddr_i),
        .IFID_RSaddr_i  (IFID_RSaddr_i),
        .IFID_RTaddr_i  (IFID_RTaddr_i),
        .IFID_UsesRT_i  (IFID_UsesRT_i),
        .Branch_i       (Branch_i),
        .Dmem_req_i     (Dmem_req_i),
        .Dmem_ack_i     (Dmem_ack_i),
        .PCWrite_o      (PCWrite_o),
        .IFIDWrite_o    (IFIDWrite_o),
        .IFIDFlush_o    (IFIDFlush_o),
        .IDEXBubble_o   (IDEXBubble_o),
        .PipeEn_o       (PipeEn_o),
        .Timeout_o      (Timeout_o),
        .StallCnt_o     (StallCnt_o),
        .FlushCnt_o     (FlushCnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("ok   %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        IDEX_MemRead_i = 1'b0;
        IDEX_RTaddr_i  = 5'd0;
        IFID_RSaddr_i  = 5'd0;
        IFID_RTaddr_i  = 5'd0;
        IFID_UsesRT_i  = 1'b0;
        Branch_i       = 1'b0;
        Dmem_req_i     = 1'b0;
        Dmem_ack_i     = 1'b0;
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rt);
        IDEX_MemRead_i = 1'b1;
        IDEX_RTaddr_i  = rt;
        IFID_RSaddr_i  = rt;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("rst_pipeen",  PipeEn_o,   1);
        chk("rst_pcwrite", PCWrite_o,  1);
        chk("rst_stall",   StallCnt_o, 0);
        chk("rst_flush",   FlushCnt_o, 0);
        chk("rst_timeout", Timeout_o,  0);

        // Load-use on rs
        next(); set_lu(5'd8); #1;
        chk("lu_pcwrite", PCWrite_o,    0);
        chk("lu_ifidwr",  IFIDWrite_o,  0);
        chk("lu_bubble",  IDEXBubble_o, 1);
        chk("lu_pipeen",  PipeEn_o,     1);
        chk("lu_flush",   IFIDFlush_o,  0);
        next(); idle(); #1;
        chk("lu_stallcnt", StallCnt_o, 1);
        chk("lu_release",  PCWrite_o,  1);

        // $0 never stalls
        next(); set_lu(5'd0); #1;
        chk("r0_pcwrite", PCWrite_o,    1);
        chk("r0_bubble",  IDEXBubble_o, 0);

        // rt match only counts when the ID instruction reads rt
        next(); IDEX_MemRead_i = 1'b1; IDEX_RTaddr_i = 5'd9; IFID_RSaddr_i = 5'd3;
        IFID_RTaddr_i = 5'd9; IFID_UsesRT_i = 1'b0; #1;
        chk("rt_nouse_pcwrite", PCWrite_o, 1);
        chk("r0_stallcnt",      StallCnt_o, 1);
        next(); IFID_UsesRT_i = 1'b1; #1;
        chk("rt_use_pcwrite", PCWrite_o,    0);
        chk("rt_use_bubble",  IDEXBubble_o, 1);
        next(); idle(); #1;
        chk("rt_stallcnt", StallCnt_o, 2);

        // Load-use wins over a taken branch; branch acts after the bubble
        next(); set_lu(5'd8); Branch_i = 1'b1; #1;
        chk("lub_bubble", IDEXBubble_o, 1);
        chk("lub_flush",  IFIDFlush_o,  0);
        next(); IDEX_MemRead_i = 1'b0; #1;
        chk("br_flushcnt_before", FlushCnt_o,  0);
        chk("br_stallcnt",        StallCnt_o,  3);
        chk("br_flush",           IFIDFlush_o, 1);
        chk("br_pcwrite",         PCWrite_o,   1);
        chk("br_bubble",          IDEXBubble_o, 0);
        next(); idle(); #1;
        chk("br_flushcnt", FlushCnt_o, 1);

        // Memory wait: req at cycle 0, ack at cycle 3; branch during freeze is held off
        next(); Dmem_req_i = 1'b1; Branch_i = 1'b1; #1;
        chk("mw_c0_pipeen",  PipeEn_o,    0);
        chk("mw_c0_pcwrite", PCWrite_o,   0);
        chk("mw_c0_flush",   IFIDFlush_o, 0);
        next(); Dmem_req_i = 1'b0; #1;
        chk("mw_c1_pipeen", PipeEn_o, 0);
        next(); #1;
        chk("mw_c2_pipeen", PipeEn_o, 0);
        next(); Branch_i = 1'b0; Dmem_ack_i = 1'b1; #1;
        chk("mw_c3_pipeen", PipeEn_o, 1);
        next(); idle(); #1;
        chk("mw_c4_pipeen",   PipeEn_o,   1);
        chk("mw_flushcnt",    FlushCnt_o, 1);

        // Same-cycle request and ack
        next(); Dmem_req_i = 1'b1; Dmem_ack_i = 1'b1; #1;
        chk("sc_pipeen", PipeEn_o, 1);
        next(); idle(); #1;
        chk("sc_after_pipeen", PipeEn_o, 1);

        // Timeout: ack never arrives
        next(); Dmem_req_i = 1'b1; #1;
        chk("to_c0_pipeen", PipeEn_o, 0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            next(); Dmem_req_i = 1'b0; #1;
            chk($sformatf("to_c%0d_pipeen", i), PipeEn_o, 0);
            chk($sformatf("to_c%0d_timeout", i), Timeout_o, 0);
        end
        next(); #1;
        chk("to_c5_pipeen",  PipeEn_o,  1);
        chk("to_c5_timeout", Timeout_o, 1);
        next(); Dmem_req_i = 1'b1; Dmem_ack_i = 1'b1; #1;
        chk("to_sticky_a", Timeout_o, 1);
        next(); Dmem_ack_i = 1'b0; #1;
        next(); Dmem_req_i = 1'b0; Dmem_ack_i = 1'b1; #1;
        chk("to_ack_pipeen", PipeEn_o, 1);
        next(); idle(); #1;
        chk("to_sticky_b", Timeout_o, 1);

        // Reset while in MEMWAIT
        next(); Dmem_req_i = 1'b1; #1;
        next(); Dmem_req_i = 1'b0; #1;
        chk("rw_wait_pipeen", PipeEn_o, 0);
        next(); rst_i = 1'b1; #1;
        chk("rw_rst_pipeen",  PipeEn_o,  1);
        chk("rw_rst_pcwrite", PCWrite_o, 1);
        next(); #1;
        chk("rw_timeout", Timeout_o,  0);
        chk("rw_stall",   StallCnt_o, 0);
        chk("rw_flush",   FlushCnt_o, 0);
        next(); rst_i = 1'b0; #1;
        chk("rw_run_pipeen",  PipeEn_o,  1);
        chk("rw_run_pcwrite", PCWrite_o, 1);

        // Saturation of the stall counter
        for (int i = 0; i < 20; i++) begin
            next(); set_lu(5'd12); #1;
            chk($sformatf("sat_%0d_cnt", i), StallCnt_o, (i < 15) ? i : 15);
            chk($sformatf("sat_%0d_bubble", i), IDEXBubble_o, 1);
        end
        next(); idle(); #1;
        chk("sat_final", StallCnt_o, 15);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
